// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling, DV strobe and framing-error pulse.
// Define UART_RX_PARITY_EN for 8E1 frames with an o_RX_Parity_Err pulse.
module uart_rx #(
  parameter int CLKS_PER_BIT = 25
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Active,
`ifdef UART_RX_PARITY_EN
  output logic       o_RX_Parity_Err,
`endif
  output logic       o_RX_Frame_Err
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int H  = (CLKS_PER_BIT - 1) / 2;
  localparam logic [CW-1:0] HALF = CW'(H);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {WAIT_HIGH, IDLE, START, DATA, PARITY, STOP, CLEANUP} state_e;
`else
  typedef enum logic [2:0] {WAIT_HIGH, IDLE, START, DATA, STOP, CLEANUP} state_e;
`endif
  state_e state_q, state_d;
  logic          meta_q, rx_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d, byte_q, byte_d;
  logic          dv_q, dv_d, act_q, act_d, ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic          par_q, par_d, perr_q, perr_d;
`endif
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      meta_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      state_q <= WAIT_HIGH;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      dv_q    <= 1'b0;
      act_q   <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      meta_q  <= i_RX_Serial;
      rx_s_q  <= meta_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      dv_q    <= dv_d;
      act_q   <= act_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    dv_d    = 1'b0;
    act_d   = act_q;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      WAIT_HIGH: begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = rx_s_q ? IDLE : WAIT_HIGH;
      end
      IDLE: begin
        cnt_d   = '0;
        bit_d   = '0;
        act_d   = !rx_s_q;
        state_d = rx_s_q ? IDLE : START;
      end
      START: begin
        cnt_d = (cnt_q == HALF) ? '0 : cnt_q + 1'b1;
        if (cnt_q == HALF) begin
          state_d = rx_s_q ? IDLE : DATA;
          act_d   = !rx_s_q;
        end
      end
      DATA: begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          shift_d[bit_q] = rx_s_q;
          bit_d          = bit_q + 1'b1;
`ifdef UART_RX_PARITY_EN
          state_d        = (bit_q == 3'd7) ? PARITY : DATA;
`else
          state_d        = (bit_q == 3'd7) ? STOP : DATA;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          par_d   = rx_s_q;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          act_d   = 1'b0;
          ferr_d  = !rx_s_q;
          state_d = rx_s_q ? CLEANUP : WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
          // A bad stop bit outranks a parity mismatch
          perr_d  = rx_s_q && (^{par_q, shift_q});
          dv_d    = rx_s_q && !(^{par_q, shift_q});
`else
          dv_d    = rx_s_q;
`endif
          byte_d  = dv_d ? shift_q : byte_q;
        end
      end
      CLEANUP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign o_RX_DV        = dv_q;
  assign o_RX_Byte      = byte_q;
  assign o_RX_Active    = act_q;
  assign o_RX_Frame_Err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign o_RX_Parity_Err = perr_q;
`endif
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
8N1 UART receiver; the companion to the team's UART transmitter (same CLKS_PER_BIT convention and bit order).
- Recovers bytes from the serial line using mid-bit sampling.
- Presents each good byte with a one-cycle valid strobe and flags framing errors.
- Sits between the board RX pin and the byte-stream consumer (command parser / loopback logic).

Parameters:
CLKS_PER_BIT, 25, i_Clock frequency / baud rate; legal range >= 8.

Ports:
i_Clock  input  1  system clock
i_Rst_L  input  1  asynchronous active-low reset
i_RX_Serial  input  1  asynchronous serial line, idle high
o_RX_DV  output  1  one-cycle pulse: o_RX_Byte holds a new good byte
o_RX_Byte  output  8  last good received byte, LSB first on the line
o_RX_Active  output  1  high while a frame is being received (START through STOP)
o_RX_Frame_Err  output  1  one-cycle pulse: stop bit sampled low

Behaviour:
- Clock and reset: one clock, i_Clock; reset is asynchronous and active-low on i_Rst_L.
- Reset values:
  - o_RX_DV=0, o_RX_Byte=8'h00, o_RX_Active=0, o_RX_Frame_Err=0.
  - Bit counter=0, clock counter=0.
  - Both synchroniser flops=1.
  - State=WAIT_HIGH.
- Input: i_RX_Serial passes through a 2-flop synchroniser; all logic uses the synchronised value (rx_s).
- Define H = (CLKS_PER_BIT-1)/2 (integer division). The clock counter must hold CLKS_PER_BIT-1.
- States:
  - WAIT_HIGH: stay until rx_s=1, then go to IDLE. Used after reset and after a framing error, so a partial frame or a break is never decoded.
  - IDLE: o_RX_Active=0, counters cleared. rx_s=0 -> START, o_RX_Active<=1.
  - START: count up to H. At count==H:
    - rx_s=0 -> DATA, counter cleared.
    - rx_s=1 -> glitch; go to IDLE, o_RX_Active<=0, no strobe.
  - DATA: count 0..CLKS_PER_BIT-1. At CLKS_PER_BIT-1, sample rx_s into shift bit[bit_idx] and clear the counter.
    - bit_idx<7 -> bit_idx+1, stay in DATA.
    - bit_idx==7 -> bit_idx<=0, go to STOP.
  - STOP: count to CLKS_PER_BIT-1, then sample rx_s.
    - 1 -> o_RX_Byte<=shift register, o_RX_DV<=1 for one cycle, go to CLEANUP.
    - 0 -> o_RX_Frame_Err<=1 for one cycle, o_RX_Byte unchanged, go to WAIT_HIGH.
    - Either way o_RX_Active<=0.
  - CLEANUP: one cycle, then IDLE.
  - Any undefined state -> IDLE.
- Sampling and latency:
  - All samples are taken H+CLKS_PER_BIT*n cycles after start detection, i.e. at bit centres ±1 clock.
  - o_RX_DV asserts H+9*CLKS_PER_BIT+1 cycles after IDLE sees rx_s=0. This is 3 cycles after the falling edge of i_RX_Serial, through the synchroniser.
- Back-to-back frames:
  - A start bit immediately following the stop bit is accepted.
  - DV occurs at the stop-bit centre, leaving >= CLKS_PER_BIT/2-2 cycles to reach IDLE before the next falling edge.
- o_RX_DV and o_RX_Frame_Err are never high in the same cycle and are never high for two consecutive cycles.
- Reset mid-frame: everything returns to reset values immediately (async). The next byte is decoded only after the line is seen high (WAIT_HIGH).
- No flow control: the consumer must take o_RX_Byte while o_RX_DV is high. The byte stays stable until the next good frame.

Optional Feature:
UART_RX_PARITY_EN
- Defined:
  - The frame is 8E1: a parity bit, sampled in state PARITY, sits between the data bits and the stop bit.
  - Adds output port o_RX_Parity_Err (1 bit, reset 0).
  - At the stop-bit sample:
    - Parity bit XOR data = 0 and stop=1 -> DV as normal.
    - Parity mismatch and stop=1 -> o_RX_Parity_Err pulses for one cycle, no DV, o_RX_Byte unchanged, go to CLEANUP.
    - Stop=0 -> frame error takes priority (no parity pulse).
  - DV latency grows by CLKS_PER_BIT.
- Undefined: no PARITY state, no o_RX_Parity_Err port, 8N1 exactly as above.

Test Plan:
- CLKS_PER_BIT=25, drive 8'hA5 8N1 -> exactly one o_RX_DV pulse, o_RX_Byte=8'hA5, o_RX_Frame_Err never high, o_RX_Active high from start detection to the stop sample.
- Bytes 8'h00, 8'hFF, 8'h3C back-to-back with no idle gap -> three DV pulses with bytes in order, each spaced 10*25 cycles apart.
- Line low for 8 cycles, then high (glitch shorter than H=12) -> no DV, no error, o_RX_Active returns to 0; a following 8'h5A frame is received correctly.
- 8'h81 with stop bit driven low, line held low for 40 more cycles, then released -> one o_RX_Frame_Err pulse, no DV, o_RX_Byte keeps its previous value; the next frame 8'h42 is received correctly.
- Assert i_Rst_L low during data bit 4 of a frame -> outputs reset asynchronously; the remainder of that frame produces no DV; the next full frame 8'h99 is received.
- UART_RX_PARITY_EN: 8'h07 with parity=1 -> DV, byte=8'h07; 8'h07 with parity=0 -> o_RX_Parity_Err pulse, no DV.
